viterbi_decoder: RTL and testbench
==================================

Name: viterbi_decoder

Overview:
- Hard-decision Viterbi decoder for one rate-1/2 recursive systematic convolutional (RSC) turbo constituent code: K=3, feedback g0=7 (octal), feedforward g1=5.
- Accepts one (sys, parity) bit pair per valid cycle into a block of N symbols.
- Runs add-compare-select (ACS) per symbol, traces back from the best state, then emits the N decoded bits serially.
- Sits after the demodulator/hard slicer in the turbo receive path.

Parameters:
- N, 16, symbols per block (≥2).
- PM_W, 8, path-metric width in bits.

Ports:
- Turbo_clk  input  1  single clock; all logic on its rising edge.
- rst  input  1  synchronous, active-high reset.
- sys  input  1  received systematic hard bit.
- parity  input  1  received parity hard bit.
- Data_Valid  input  1  sys/parity valid this cycle.
- Hard_out_bits  output  1  decoded bit stream, first-in bit first.
- Turbo_done  output  1  high for exactly N cycles while Hard_out_bits carries decoded bits.

Behaviour:
- Encoder model. State index {s1,s0}. Input u gives:
  - feedback a = u^s1^s0
  - parity p = a^s0
  - systematic = u
  - next state {a,s1}
- Trellis. Next state ns has predecessors {ns[0],x} for x∈{0,1}, with branch input u = ns[1]^ns[0]^x.
- Branch metric = (sys≠u)+(parity≠p), range 0..2.
- ACS: new PM[ns] = min over x of PM[{ns[0],x}] + BM. Tie selects x=0. Survivor bit x is stored at mem[t][ns].
- Normalization: if every new PM ≥ 2^(PM_W-1), subtract 2^(PM_W-1) from all of them in the same cycle. There is no wrap or overflow otherwise.
- Block start: PM[0]=0, PM[1..3]=2^(PM_W-2). The symbol counter t=0.
- FSM:
  - ACS: each cycle with Data_Valid=1, do the ACS and increment t. Data_Valid=0 pauses with no state change. When t reaches N-1 with Data_Valid=1, go to BEST.
  - BEST (1 cycle): select the state with minimum PM; a tie selects the lowest index. Go to TB.
  - TB (N cycles, t=N-1 down to 0): x = mem[t][st]; dec[t] = st[1]^st[0]^x; st ← {st[0],x}. Go to OUT.
  - OUT (N cycles): Hard_out_bits = dec[i] for i=0..N-1 (registered), with Turbo_done=1. Then go to ACS and reinitialize the metrics.
- Latency: if the N-th valid symbol is sampled at edge k, Turbo_done is first high after edge k+N+2 and last high after edge k+2N+1.
- Data_Valid and inputs are ignored in BEST/TB/OUT; those symbols are dropped and not buffered.
- Outside OUT: Hard_out_bits=0 and Turbo_done=0.
- Reset: takes effect on any edge with rst=1, including mid-block or mid-output.
  - Go to ACS, t=0, metrics initialized.
  - Hard_out_bits=0, Turbo_done=0.
  - Survivor memory contents don't care.
- Storage:
  - Survivor memory: N×4 bits.
  - Decoded buffer: N bits.
  - Counters: ceil(log2 N) bits.

Decomposition:
- Package viterbi_pkg:
  - FSM state enum (ACS, BEST, TB, OUT)
  - state count 4
  - initial-metric constant
  - function returning expected {u,p} for (state,x)
- One natural sub-module, viterbi_acs_unit: the combinational 4-state BM+ACS+normalization, taking PM[0..3] and sys/parity and returning new PM[0..3] and 4 survivor bits.
- Traceback, buffer and FSM stay in the top.

Test Plan:
1. All-zero: N=16, sys=0, parity=0, Data_Valid=1 continuous.
   - Required: Turbo_done high 16 cycles starting 18 cycles after the 16th sample.
   - Hard_out_bits all 0.
   - Then Turbo_done low.
2. Impulse: u=1,0,0,… encoded to (sys,parity) = (1,1),(0,1),(0,1),(0,0),(0,1),(0,1),(0,0)… (period-3 parity tail 1,1,0).
   - Required: decoded 1 followed by fifteen 0s.
3. Single error: same as case 2 with the parity of symbol 5 flipped.
   - Required: output identical to case 2.
4. Data_Valid gaps: case 2 stimulus with Data_Valid=0 for 3 cycles after every 4 symbols.
   - Required: same decoded bits.
   - Turbo_done onset = 18 cycles after the 16th valid sample.
5. Back-to-back: two blocks, zero then impulse, Data_Valid held 1 throughout; symbols during BEST/TB/OUT are dropped.
   - Required: block 2 starts at the first valid cycle after OUT ends and decodes correctly.
6. Reset mid-OUT: rst=1 for 1 cycle during the 5th output bit.
   - Required: Turbo_done=0 and Hard_out_bits=0 the next cycle.
   - A fresh block then decodes per case 1.

Source files
------------

// File: rtl/viterbi_pkg.sv
// Shared types and trellis helpers for the K=3 RSC (7,5) hard-decision Viterbi decoder.
package viterbi_pkg;

  typedef enum logic [1:0] {ACS, BEST, TB, OUT} fsm_t;

  localparam int NUM_ST = 4;

  // States 1..3 start a quarter-range behind state 0 so the trellis is anchored at zero.
  function automatic int init_pm(input int pm_w);
    return 1 << (pm_w - 2);
  endfunction

  // Expected {u,p} on the branch into ns from predecessor {ns[0],x}.
  function automatic logic [1:0] branch_up(input logic [1:0] ns, input logic x);
    logic u;
    u = ns[1] ^ ns[0] ^ x;
    return {u, ns[1] ^ x};
  endfunction

endpackage

// File: rtl/viterbi_acs_unit.sv
// Combinational 4-state branch metric, add-compare-select and metric normalization.
module viterbi_acs_unit
  import viterbi_pkg::*;
#(
  parameter int PM_W = 8
) (
  input  logic [NUM_ST-1:0][PM_W-1:0] pm,
  input  logic                        sys,
  input  logic                        parity,
  output logic [NUM_ST-1:0][PM_W-1:0] pm_next,
  output logic [NUM_ST-1:0]           surv
);

  localparam logic [PM_W-1:0] HALF = {1'b1, {(PM_W-1){1'b0}}};

  logic [NUM_ST-1:0][PM_W-1:0] sel_pm;
  logic [NUM_ST-1:0]           big;

  generate
    for (genvar g = 0; g < NUM_ST; g++) begin : g_st
      localparam logic [1:0] NS  = 2'(g);
      localparam logic [1:0] UP0 = branch_up(NS, 1'b0);
      localparam logic [1:0] UP1 = branch_up(NS, 1'b1);
      logic [1:0]      bm0, bm1;
      logic [PM_W-1:0] c0, c1;

      assign bm0 = {1'b0, sys != UP0[1]} + {1'b0, parity != UP0[0]};
      assign bm1 = {1'b0, sys != UP1[1]} + {1'b0, parity != UP1[0]};
      assign c0  = pm[{NS[0], 1'b0}] + PM_W'(bm0);
      assign c1  = pm[{NS[0], 1'b1}] + PM_W'(bm1);
      // strict compare: ties keep the x=0 predecessor
      assign surv[g]    = c1 < c0;
      assign sel_pm[g]  = surv[g] ? c1 : c0;
      assign big[g]     = sel_pm[g][PM_W-1];
      assign pm_next[g] = (&big) ? (sel_pm[g] - HALF) : sel_pm[g];
    end
  endgenerate

endmodule

// File: rtl/viterbi_decoder.sv
// Block Viterbi decoder: ACS over N symbols, best-state pick, traceback, serial output.
module viterbi_decoder
  import viterbi_pkg::*;
#(
  parameter int N    = 16,
  parameter int PM_W = 8
) (
  input  logic Turbo_clk,
  input  logic rst,
  input  logic sys,
  input  logic parity,
  input  logic Data_Valid,
  output logic Hard_out_bits,
  output logic Turbo_done
);

  localparam int              TW      = (N > 1) ? $clog2(N) : 1;
  localparam logic [PM_W-1:0] PM_INIT = PM_W'(init_pm(PM_W));
  localparam logic [TW-1:0]   LAST    = TW'(N - 1);

  fsm_t                        state;
  logic [TW-1:0]               t;
  logic [NUM_ST-1:0][PM_W-1:0] pm, pm_next;
  logic [NUM_ST-1:0]           surv;
  logic [NUM_ST-1:0]           mem [N];
  logic [N-1:0]                dec;
  logic [1:0]                  st, best;
  logic                        x;

  viterbi_acs_unit #(.PM_W(PM_W)) u_acs (
    .pm      (pm),
    .sys     (sys),
    .parity  (parity),
    .pm_next (pm_next),
    .surv    (surv)
  );

  // strict compare keeps the lowest index on ties
  always_comb begin
    best = 2'd0;
    for (int i = 1; i < NUM_ST; i++)
      if (pm[i] < pm[best]) best = 2'(i);
  end

  assign x = mem[t][st];

  always_ff @(posedge Turbo_clk) begin
    if (state == ACS && Data_Valid) mem[t] <= surv;
  end

  // t counts symbols up in ACS, down in TB, and reused as the output index in OUT
  always_ff @(posedge Turbo_clk) begin
    if (rst) begin
      state         <= ACS;
      t             <= '0;
      pm            <= {{(NUM_ST-1){PM_INIT}}, {PM_W{1'b0}}};
      st            <= 2'd0;
      Hard_out_bits <= 1'b0;
      Turbo_done    <= 1'b0;
    end else begin
      Hard_out_bits <= 1'b0;
      Turbo_done    <= 1'b0;
      case (state)
        ACS: if (Data_Valid) begin
          pm <= pm_next;
          if (t == LAST) state <= BEST;
          else           t     <= t + TW'(1);
        end
        BEST: begin
          st    <= best;
          state <= TB;
        end
        TB: begin
          dec[t] <= st[1] ^ st[0] ^ x;
          st     <= {st[0], x};
          if (t == '0) state <= OUT;
          else         t     <= t - TW'(1);
        end
        OUT: begin
          Hard_out_bits <= dec[t];
          Turbo_done    <= 1'b1;
          if (t == LAST) begin
            state <= ACS;
            t     <= '0;
            pm    <= {{(NUM_ST-1){PM_INIT}}, {PM_W{1'b0}}};
          end else begin
            t <= t + TW'(1);
          end
        end
        default: state <= ACS;
      endcase
    end
  end

endmodule

// File: tb/tb_viterbi_decoder.sv
// Randomized and directed checks of viterbi_decoder against a forward-trellis reference decoder.
module tb_viterbi_decoder;

  localparam int N    = 16;
  localparam int PM_W = 8;

  typedef logic [N-1:0] blk_t;

  logic Turbo_clk = 1'b0;
  logic rst, sys, parity, Data_Valid;
  logic Hard_out_bits, Turbo_done;
  int   cyc = 0;
  int   n_run = 0, n_fail = 0;

  always #5 Turbo_clk = ~Turbo_clk;
  always @(posedge Turbo_clk) cyc <= cyc + 1;

  viterbi_decoder #(.N(N), .PM_W(PM_W)) dut (
    .Turbo_clk     (Turbo_clk),
    .rst           (rst),
    .sys           (sys),
    .parity        (parity),
    .Data_Valid    (Data_Valid),
    .Hard_out_bits (Hard_out_bits),
    .Turbo_done    (Turbo_done)
  );

  task automatic chk(input string tag, input int got, input int exp);
    n_run++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d exp %0d", tag, got, exp);
    end
  endtask

  function automatic int ob();
    return int'({Turbo_done, Hard_out_bits});
  endfunction

  // RSC encoder: a=u^s1^s0, p=a^s0, next state {a,s1}
  function automatic void encode(input blk_t u, output blk_t s, output blk_t p);
    int s1 = 0, s0 = 0, a;
    for (int i = 0; i < N; i++) begin
      a    = int'(u[i]) ^ s1 ^ s0;
      s[i] = u[i];
      p[i] = 1'(a ^ s0);
      s0   = s1;
      s1   = a;
    end
  endfunction

  // Forward trellis walk over every (state,u) edge with unbounded integer metrics.
  function automatic blk_t ref_decode(input blk_t s, input blk_t p);
    int   pm[4], npm[4];
    int   pred[N][4], ub[N][4];
    int   s1, s0, a, pb, ns, m, best, st;
    blk_t d;
    pm[0] = 0;
    for (int i = 1; i < 4; i++) pm[i] = 1 << (PM_W - 2);
    for (int t = 0; t < N; t++) begin
      for (int i = 0; i < 4; i++) npm[i] = 1 << 30;
      for (int ps = 0; ps < 4; ps++)
        for (int u = 0; u < 2; u++) begin
          s1 = (ps >> 1) & 1;
          s0 = ps & 1;
          a  = u ^ s1 ^ s0;
          pb = a ^ s0;
          ns = a * 2 + s1;
          m  = pm[ps] + ((int'(s[t]) != u) ? 1 : 0) + ((int'(p[t]) != pb) ? 1 : 0);
          if (m < npm[ns]) begin
            npm[ns]     = m;
            pred[t][ns] = ps;
            ub[t][ns]   = u;
          end
        end
      pm = npm;
    end
    best = 0;
    for (int i = 1; i < 4; i++) if (pm[i] < pm[best]) best = i;
    st = best;
    for (int t = N - 1; t >= 0; t--) begin
      d[t] = 1'(ub[t][st]);
      st   = pred[t][st];
    end
    return d;
  endfunction

  task automatic drive(input logic s, input logic p, input logic v);
    sys = s; parity = p; Data_Valid = v;
    @(posedge Turbo_clk);
    #1;
  endtask

  // gaps: 0 none, 1 three idle cycles after every 4 symbols, 2 random idles
  task automatic send_block(input blk_t s, input blk_t p, input int gaps, input bit hold,
                            output int k);
    k = 0;
    for (int i = 0; i < N; i++) begin
      if (gaps == 1 && i != 0 && i % 4 == 0)
        repeat (3) drive(1'($urandom), 1'($urandom), 1'b0);
      if (gaps == 2)
        repeat ($urandom_range(0, 2)) drive(1'($urandom), 1'($urandom), 1'b0);
      drive(s[i], p[i], 1'b1);
      k = cyc;
    end
    if (!hold) Data_Valid = 1'b0;
  endtask

  task automatic check_out(input string tag, input blk_t exp, input int k);
    int w = 0;
    @(negedge Turbo_clk);
    while (!Turbo_done && w < 4 * N) begin
      @(negedge Turbo_clk);
      w++;
    end
    if (!Turbo_done) begin
      chk({tag, "_timeout"}, 0, 1);
      return;
    end
    chk({tag, "_onset"}, cyc - k, N + 2);
    for (int i = 0; i < N; i++) begin
      chk($sformatf("%s_bit%0d", tag, i), ob(), int'({1'b1, exp[i]}));
      @(negedge Turbo_clk);
    end
    chk({tag, "_end"}, ob(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout exp finish");
    $fatal(1);
  end

  initial begin
    blk_t s, p, p2, u, e;
    int   k, k2;
    rst = 1'b1; sys = 1'b0; parity = 1'b0; Data_Valid = 1'b0;
    repeat (2) @(posedge Turbo_clk);
    @(negedge Turbo_clk);
    chk("rst_state", ob(), 0);
    rst = 1'b0;

    send_block('0, '0, 0, 1'b0, k);
    check_out("zero", '0, k);

    encode(blk_t'(1), s, p);
    send_block(s, p, 0, 1'b0, k);
    check_out("imp", blk_t'(1), k);

    p2 = p;
    p2[4] = ~p2[4];
    send_block(s, p2, 0, 1'b0, k);
    check_out("imp_err", blk_t'(1), k);

    send_block(s, p, 1, 1'b0, k);
    check_out("imp_gap", blk_t'(1), k);

    // back-to-back with valid held high; symbols during BEST/TB/OUT must be dropped
    send_block('0, '0, 0, 1'b1, k);
    fork
      check_out("b2b_a", '0, k);
      begin
        repeat (2 * N + 1) drive(1'b1, 1'b0, 1'b1);
        send_block(s, p, 0, 1'b0, k2);
      end
    join
    check_out("b2b_b", blk_t'(1), k2);

    // reset while the 5th output bit is on the line; the 6th bit would be 1
    u = blk_t'($urandom);
    u[5] = 1'b1;
    encode(u, s, p);
    send_block(s, p, 0, 1'b0, k);
    repeat (N + 7) @(negedge Turbo_clk);
    chk("r6_pre", ob(), int'({1'b1, u[4]}));
    rst = 1'b1;
    @(negedge Turbo_clk);
    chk("r6_rst", ob(), 0);
    rst = 1'b0;
    @(negedge Turbo_clk);
    chk("r6_idle", ob(), 0);
    send_block('0, '0, 0, 1'b0, k);
    check_out("r6_zero", '0, k);

    for (int b = 0; b < 12; b++) begin
      if (b % 3 == 2) begin
        s = blk_t'($urandom);
        p = blk_t'($urandom);
      end else begin
        encode(blk_t'($urandom), s, p);
        for (int i = 0; i < N; i++) begin
          if ($urandom_range(0, 9) == 0) p[i] = ~p[i];
          if ($urandom_range(0, 11) == 0) s[i] = ~s[i];
        end
      end
      e = ref_decode(s, p);
      send_block(s, p, (b % 2 == 1) ? 2 : 0, 1'b0, k);
      check_out($sformatf("rnd%0d", b), e, k);
    end

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
